// File: rtl/pamac_pkg.sv
// Shared constants and types for the PAMAC Booth radix-4 control sequencer.
package pamac_pkg;

    localparam int unsigned DATA_W  = 16;
    localparam int unsigned DIGITS  = DATA_W / 2;
    localparam int unsigned SHIFT_W = 3;

    // One recoded radix-4 digit: value = (neg ? -1 : +1) * (double ? 2 : 1), or 0 when !nonzero
    typedef struct packed {
        logic neg;
        logic double;
        logic nonzero;
    } booth_digit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/pamac_booth_seq_if.sv
// Operand handshake between the PE operand buffers and the Booth sequencer.
interface pamac_booth_seq_if;
    import pamac_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] mult;
    logic              sel_in;

    modport master (output in_valid, output mult, output sel_in, input in_ready);
    modport slave  (input in_valid, input mult, input sel_in, output in_ready);

endinterface

// File: rtl/pamac_booth_seq_recoder.sv
// Combinational radix-4 Booth recoder: per-digit records plus the non-zero digit mask.
module booth_r4_recoder
    import pamac_pkg::*;
(
    input  logic                        [DATA_W-1:0] mult,
    output booth_digit_t [DIGITS-1:0]                digits,
    output logic                        [DIGITS-1:0] mask
);

    logic [DATA_W:0] m_ext;
    logic [2:0]      trip;

    // Bit 0 of m_ext stands in for mult[-1] = 0
    assign m_ext = {mult, 1'b0};

    always_comb begin
        digits = '0;
        mask   = '0;
        trip   = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            trip = m_ext[2*k +: 3];
            case (trip)
                3'b001, 3'b010: digits[k] = '{neg: 1'b0, double: 1'b0, nonzero: 1'b1};
                3'b011:         digits[k] = '{neg: 1'b0, double: 1'b1, nonzero: 1'b1};
                3'b100:         digits[k] = '{neg: 1'b1, double: 1'b1, nonzero: 1'b1};
                3'b101, 3'b110: digits[k] = '{neg: 1'b1, double: 1'b0, nonzero: 1'b1};
                default:        digits[k] = '0;
            endcase
            mask[k] = digits[k].nonzero;
        end
    end

endmodule

// File: rtl/pamac_booth_seq.sv
// PAMAC Booth sequencer: issues one registered datapath control word per non-zero radix-4 digit.
// Optional issued-op counter on perf_ops when PAMAC_SEQ_PERF_CNT_EN is defined.
module pamac_booth_seq
    import pamac_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    pamac_booth_seq_if.slave   opnd,
    output logic               mul_sel,
    output logic [SHIFT_W-1:0] shift_ctrl,
    output logic               double,
    output logic               neg,
    output logic               first_cycle,
    output logic               DFF_en,
    output logic               busy,
    output logic               last,
    output logic [31:0]        perf_ops
);

    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_RUN  = 1'(RUN);

    logic [0:0] state_q, state_d;
    booth_digit_t [DIGITS-1:0] digits_q, digits_d, rec_digits, src_dig;
    logic [DIGITS-1:0] rec_mask, pend_mask, src_mask, rem;
    logic in_ready_q, in_ready_d, accept;
    logic sel_d, dbl_d, neg_d, first_d, busy_d, last_d;
    logic [SHIFT_W-1:0] shift_d, k_sel;

    booth_r4_recoder u_rec (
        .mult   (opnd.mult),
        .digits (rec_digits),
        .mask   (rec_mask)
    );

    assign opnd.in_ready = in_ready_q;
    assign accept        = opnd.in_valid & in_ready_q;

    // Digits still to issue are those whose nonzero flag has not been cleared
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            pend_mask[i] = digits_q[i].nonzero;
        end
    end

    // Next op selection; outputs are computed one cycle ahead and registered
    always_comb begin
        state_d  = S_IDLE;
        digits_d = digits_q;
        sel_d    = mul_sel;
        shift_d  = shift_ctrl;
        dbl_d    = 1'b0;
        neg_d    = 1'b0;
        first_d  = 1'b0;
        busy_d   = 1'b0;
        last_d   = 1'b0;
        src_mask = pend_mask;
        src_dig  = digits_q;
        k_sel    = '0;
        rem      = '0;

        if (accept) begin
            sel_d    = opnd.sel_in;
            src_mask = rec_mask;
            src_dig  = rec_digits;
        end

        if (accept && (rec_mask == '0)) begin
            // Zero operand: +1 now and a queued -1 at k=0 so the product nets to 0
            busy_d      = 1'b1;
            first_d     = 1'b1;
            shift_d     = '0;
            digits_d    = '0;
            digits_d[0] = '{neg: 1'b1, double: 1'b0, nonzero: 1'b1};
        end else if ((accept || (state_q == S_RUN)) && (src_mask != '0)) begin
            for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
                if (src_mask[i]) k_sel = SHIFT_W'(i);
            end
            rem                   = src_mask;
            rem[k_sel]            = 1'b0;
            digits_d              = src_dig;
            digits_d[k_sel].nonzero = 1'b0;
            busy_d  = 1'b1;
            first_d = accept;
            shift_d = k_sel;
            dbl_d   = src_dig[k_sel].double;
            neg_d   = src_dig[k_sel].neg;
            last_d  = (rem == '0);
        end

        if (busy_d) state_d = S_RUN;
        in_ready_d = ~busy_d | last_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            digits_q    <= '0;
            in_ready_q  <= 1'b1;
            mul_sel     <= 1'b0;
            shift_ctrl  <= '0;
            double      <= 1'b0;
            neg         <= 1'b0;
            first_cycle <= 1'b0;
            DFF_en      <= 1'b0;
            busy        <= 1'b0;
            last        <= 1'b0;
        end else begin
            state_q     <= state_d;
            digits_q    <= digits_d;
            in_ready_q  <= in_ready_d;
            mul_sel     <= sel_d;
            shift_ctrl  <= shift_d;
            double      <= dbl_d;
            neg         <= neg_d;
            first_cycle <= first_d;
            DFF_en      <= busy_d;
            busy        <= busy_d;
            last        <= last_d;
        end
    end

`ifdef PAMAC_SEQ_PERF_CNT_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (busy) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_ops = perf_q;
`else
    assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_pamac_booth_seq.sv
// Scoreboard bench for pamac_booth_seq: arithmetic Booth model queues expected ops per operand.
`timescale 1ns/1ps
module tb_pamac_booth_seq;
    import pamac_pkg::*;

    typedef struct {
        int k;
        bit dbl;
        bit neg;
        bit first;
        bit last;
        bit sel;
        int prod;
    } exp_t;

`ifdef PAMAC_SEQ_PERF_CNT_EN
    localparam int PERF_EXP = 8;
`else
    localparam int PERF_EXP = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mul_sel, double, neg, first_cycle, DFF_en, busy, last;
    logic [SHIFT_W-1:0] shift_ctrl;
    logic [31:0] perf_ops;

    int total = 0;
    int bad = 0;
    int acc = 0;
    exp_t sbq[$];

    pamac_booth_seq_if bus();

    pamac_booth_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opnd        (bus),
        .mul_sel     (mul_sel),
        .shift_ctrl  (shift_ctrl),
        .double      (double),
        .neg         (neg),
        .first_cycle (first_cycle),
        .DFF_en      (DFF_en),
        .busy        (busy),
        .last        (last),
        .perf_ops    (perf_ops)
    );

    always #5 clk = ~clk;

    // Digit d_k = -2*m[2k+1] + m[2k] + m[2k-1]; zero operand becomes +1 then -1 at k=0
    function automatic void push_expected(input logic [15:0] m, input logic s);
        logic [16:0] e;
        exp_t q[$];
        exp_t x;
        int d;
        e = {m, 1'b0};
        for (int j = 0; j < 8; j++) begin
            d = -2 * int'(e[2*j+2]) + int'(e[2*j+1]) + int'(e[2*j]);
            if (d != 0) begin
                x = '{k: j, dbl: (d == 2 || d == -2), neg: (d < 0), first: 1'b0, last: 1'b0,
                      sel: s, prod: int'($signed(m))};
                q.push_back(x);
            end
        end
        if (q.size() == 0) begin
            x = '{k: 0, dbl: 1'b0, neg: 1'b0, first: 1'b0, last: 1'b0, sel: s, prod: 0};
            q.push_back(x);
            x.neg = 1'b1;
            q.push_back(x);
        end
        q[0].first = 1'b1;
        q[q.size()-1].last = 1'b1;
        foreach (q[i]) sbq.push_back(q[i]);
    endfunction

    // Pops one expected op per busy cycle and rebuilds the datapath product from the issued ops
    always @(negedge clk) begin : mon
        exp_t e;
        int v;
        logic [9:0] got, want;
        if (rst_n) begin
            if (busy) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_op k=%0d t=%0t", shift_ctrl, $time);
                end else begin
                    e = sbq.pop_front();
                    got  = {shift_ctrl, double, neg, first_cycle, last, mul_sel, DFF_en, bus.in_ready};
                    want = {3'(e.k), e.dbl, e.neg, e.first, e.last, e.sel, 1'b1, e.last};
                    if (got !== want) begin
                        bad++;
                        $display("FAIL op_ctrl got=%b want=%b (k,dbl,neg,first,last,sel,en,rdy) t=%0t",
                                 got, want, $time);
                    end
                    v = (double ? 2 : 1) << (2 * int'(shift_ctrl));
                    if (neg) v = -v;
                    acc = first_cycle ? v : acc + v;
                    if (e.last) begin
                        total++;
                        if (acc !== e.prod) begin
                            bad++;
                            $display("FAIL product got=%0d want=%0d t=%0t", acc, e.prod, $time);
                        end
                    end
                end
            end else begin
                total++;
                if ({double, neg, first_cycle, last, DFF_en} !== 5'b0) begin
                    bad++;
                    $display("FAIL idle_ctrl got=%b want=00000 t=%0t",
                             {double, neg, first_cycle, last, DFF_en}, $time);
                end
            end
        end
    end

    task automatic send(input logic [15:0] m, input logic s);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!bus.in_ready) begin
            bad++;
            $display("FAIL send_ready_timeout got=0 want=1 t=%0t", $time);
        end
        bus.in_valid = 1'b1;
        bus.mult     = m;
        bus.sel_in   = s;
        push_expected(m, s);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.mult     = 16'($urandom);
        bus.sel_in   = 1'($urandom);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busy || sbq.size() != 0) && n < 200);
        total++;
        if (busy || sbq.size() != 0) begin
            bad++;
            $display("FAIL %s_drain busy=%0b pending=%0d want busy=0 pending=0", name, busy, sbq.size());
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if ({bus.in_ready, mul_sel, shift_ctrl, double, neg, first_cycle, DFF_en, busy, last} !== {1'b1, 10'b0}) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b",
                     {bus.in_ready, mul_sel, shift_ctrl, double, neg, first_cycle, DFF_en, busy, last},
                     {1'b1, 10'b0});
        end
        total++;
        if (perf_ops !== 32'd0) begin
            bad++;
            $display("FAIL reset_perf got=%0d want=0", perf_ops);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_two_ops();
        send(16'h0003, 1'b1);
        wait_idle("x0003");
        total++;
        if ({mul_sel, shift_ctrl} !== {1'b1, 3'd1}) begin
            bad++;
            $display("FAIL hold_after_0003 got=%b want=1001", {mul_sel, shift_ctrl});
        end
    endtask

    task automatic test_min_neg();
        send(16'h8000, 1'b0);
        wait_idle("x8000");
        total++;
        if ({mul_sel, shift_ctrl} !== {1'b0, 3'd7}) begin
            bad++;
            $display("FAIL hold_after_8000 got=%b want=0111", {mul_sel, shift_ctrl});
        end
    endtask

    task automatic test_zero();
        send(16'h0000, 1'b1);
        wait_idle("x0000");
        total++;
        if (shift_ctrl !== 3'd0) begin
            bad++;
            $display("FAIL hold_after_zero got=%0d want=0", shift_ctrl);
        end
    endtask

    task automatic test_all_digits();
        send(16'h5555, 1'b0);
        wait_idle("x5555");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.mult     = 16'hFFFF;
        bus.sel_in   = 1'b1;
        push_expected(16'hFFFF, 1'b1);
        @(posedge clk);
        #1;
        bus.mult   = 16'h0003;
        bus.sel_in = 1'b0;
        push_expected(16'h0003, 1'b0);
        @(negedge clk);
        total++;
        if ({busy, first_cycle, last, bus.in_ready} !== 4'b1111) begin
            bad++;
            $display("FAIL b2b_first_op got=%b want=1111", {busy, first_cycle, last, bus.in_ready});
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, first_cycle} !== 2'b11) begin
            bad++;
            $display("FAIL b2b_no_bubble got=%b want=11", {busy, first_cycle});
        end
        wait_idle("b2b");
    endtask

    task automatic test_mid_reset();
        int cnt = 0;
        int n = 0;
        send(16'h5555, 1'b1);
        while (cnt < 3 && n < 50) begin
            @(negedge clk);
            n++;
            if (busy) cnt++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.in_ready, mul_sel, shift_ctrl, double, neg, first_cycle, DFF_en, busy, last} !== {1'b1, 10'b0}) begin
            bad++;
            $display("FAIL midreset_outputs got=%b want=%b",
                     {bus.in_ready, mul_sel, shift_ctrl, double, neg, first_cycle, DFF_en, busy, last},
                     {1'b1, 10'b0});
        end
        total++;
        if (perf_ops !== 32'd0) begin
            bad++;
            $display("FAIL midreset_perf got=%0d want=0", perf_ops);
        end
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(16'h5555, 1'b0);
        wait_idle("rerun");
        total++;
        if (perf_ops !== 32'(PERF_EXP)) begin
            bad++;
            $display("FAIL perf_after_rerun got=%0d want=%0d", perf_ops, PERF_EXP);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            send(16'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle("random");
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.mult     = '0;
        bus.sel_in   = 1'b0;
        test_reset();
        test_two_ops();
        test_min_neg();
        test_zero();
        test_all_digits();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pamac_booth_seq.md
Name: pamac_booth_seq

Overview:
- Control-side encoder for the PAMAC accumulate datapath.
- Accepts a 16-bit signed multiplier operand and radix-4 Booth-recodes it.
- Skips zero digits and issues one datapath control word per non-zero digit: operand select, shift, double, neg, first-cycle and accumulator enable.
- Sits between the PE operand buffers and the PAMAC accumulator.
- Signals the cycle on which the datapath's combinational result Y is final.

Parameters:
- DATA_W, 16, multiplier width in bits (even).
- DIGITS, DATA_W/2, number of radix-4 Booth digits (8).
- SHIFT_W, 3, digit-index width, clog2(DIGITS).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  multiplier operand offered.
- in_ready  output  1  sequencer can accept an operand this cycle.
- mult  input  DATA_W  signed two's-complement multiplier.
- sel_in  input  1  multiplicand select to forward (0: W, 1: A).
- mul_sel  output  1  registered multiplicand select.
- shift_ctrl  output  SHIFT_W  digit index k; the datapath shifts the multiplicand left by 2k.
- double  output  1  digit magnitude is 2.
- neg  output  1  digit is negative; the datapath inverts and adds carry-in 1.
- first_cycle  output  1  first op of the product; the datapath adds the bias T instead of the accumulator.
- DFF_en  output  1  accumulator register enable.
- busy  output  1  an op is issued this cycle.
- last  output  1  final op; the datapath Y is valid this cycle.
- perf_ops  output  32  issued-op counter (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; all other outputs 0, including perf_ops.
- Booth digit k uses triplet {mult[2k+1], mult[2k], mult[2k-1]}, with mult[-1]=0.
  - 000, 111 → 0.
  - 001, 010 → +1.
  - 011 → +2 (double=1).
  - 100 → -2 (double=1, neg=1).
  - 101, 110 → -1 (neg=1).
- States: IDLE, RUN.
  - Accept when in_valid & in_ready.
  - On accept, register the recoded digits (magnitude/sign), a DIGITS-bit non-zero mask and sel_in. Go to RUN.
  - First op is issued the cycle after accept. No combinational path from mult to the control outputs.
- RUN issue rules:
  - Each cycle, issue the lowest-index set mask bit: shift_ctrl=k, double/neg per digit, DFF_en=1, busy=1. Clear that bit.
  - first_cycle=1 only on the first op of an operand.
  - last=1 when no mask bits remain after this op.
- Latency: N non-zero digits give exactly N consecutive op cycles (1 ≤ N ≤ 8). No bubbles.
- All-zero multiplier (mask empty):
  - Issue two ops: +1 at k=0 with first_cycle=1, then -1 at k=0 with last=1.
  - The net product is 0, so Y=T.
- in_ready:
  - 1 in IDLE.
  - 1 in RUN only on the last cycle, allowing back-to-back operands.
  - If an operand is accepted on a last cycle, the next cycle is that operand's first op (first_cycle=1). Otherwise return to IDLE.
- When busy=0: DFF_en, first_cycle, last, double and neg are 0. shift_ctrl and mul_sel hold their values.
- mult and sel_in are ignored when not accepted.
- Mid-operation async reset: immediate return to IDLE; the pending product is discarded.

Optional Feature:
- Macro PAMAC_SEQ_PERF_CNT_EN.
- Defined: perf_ops is a 32-bit counter, incremented on every busy cycle and wrapping at 2^32. It is cleared by reset only.
- Undefined: perf_ops is tied to 0 and no counter flops exist.

Decomposition:
- Shared package pamac_pkg:
  - DATA_W, DIGITS, SHIFT_W constants.
  - Booth digit typedef {neg, double, nonzero}.
  - State enum {IDLE, RUN}.
- Sub-module booth_r4_recoder: purely combinational, maps mult to per-digit records and the non-zero mask.
- The lowest-set-bit priority encoder stays inline in the sequencer.

Test Plan:
- mult=0x0003, sel_in=1 → two ops.
  - Op 1: k=0, neg=1, double=0, first=1.
  - Op 2: k=1, neg=0, double=0, last=1.
  - mul_sel=1 throughout.
- mult=0x8000 → one op: k=7, double=1, neg=1, first=1, last=1, DFF_en=1.
- mult=0x0000 → two ops at k=0: first (+1) then last (-1, neg=1). Datapath Y equals T.
- mult=0x5555 → eight ops, k=0..7, all +1. first only on k=0, last only on k=7, in_ready high only on the k=7 cycle.
- Back-to-back: hold in_valid with 0xFFFF then 0x0003.
  - First operand: one op, k=0, neg=1, with first=last=1.
  - Second operand: accepted that same cycle; its first op (first=1) follows with no idle cycle.
- Assert rst_n=0 during the 3rd op of 0x5555 → all outputs 0 immediately, in_ready=1. perf_ops=0 with PAMAC_SEQ_PERF_CNT_EN; after re-run, perf_ops=8.
